// File: rtl/buf_drive_sequencer.sv
// buf_drive_sequencer: staggered enable/disable of NSEG paralleled
// output-buffer segments, one segment per dwell, to limit di/dt.
//
// Ports:
//   CLK   rising-edge clock
//   RN    asynchronous active-low reset
//   VDD   supply pin, no functional use
//   VSS   ground pin, no functional use
//   REQ   1-cycle strobe, latch LVL (clipped to NSEG) as the target
//   LVL   requested number of enabled segments
//   STEP  extra dwell cycles between segment changes
//   KILL  synchronous emergency off, overrides REQ
//   EN    segment enables, thermometer code, registered
//   CUR   current enabled-segment count
//   BUSY  ramp in progress
//   DONE  1-cycle pulse when CUR reaches the target
module buf_drive_sequencer #(
    parameter int NSEG   = 4,
    parameter int STEP_W = 4,
    localparam int LW    = $clog2(NSEG + 1)
) (
    input  logic              CLK,
    input  logic              RN,
    inout  wire               VDD,
    inout  wire               VSS,
    input  logic              REQ,
    input  logic [LW-1:0]     LVL,
    input  logic [STEP_W-1:0] STEP,
    input  logic              KILL,
    output logic [NSEG-1:0]   EN,
    output logic [LW-1:0]     CUR,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DN
    } state_t;

    state_t            state;
    logic [LW-1:0]     tgt;
    logic [STEP_W-1:0] cnt;

    logic [LW-1:0] lvl_clip;
    logic [LW-1:0] tgt_nxt;
    logic [LW-1:0] cur_step;
    logic [LW-1:0] cur_nxt;
    logic          stepping;

    // Supply pins exist only for netlist connectivity.
    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    function automatic logic [NSEG-1:0] therm(input logic [LW-1:0] c);
        logic [NSEG-1:0] t;
        t = '0;
        for (int i = 0; i < NSEG; i++) begin
            t[i] = (i < int'(c));
        end
        return t;
    endfunction

    assign lvl_clip = (LVL > LW'(NSEG)) ? LW'(NSEG) : LVL;
    assign tgt_nxt  = REQ ? lvl_clip : tgt;
    assign stepping = (cnt == '0);

    // A step always follows the direction held before this edge; a
    // simultaneous retarget only steers the decision made after it.
    assign cur_step = (state == UP) ? CUR + LW'(1) : CUR - LW'(1);
    assign cur_nxt  = stepping ? cur_step : CUR;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            CUR   <= '0;
            tgt   <= '0;
            cnt   <= '0;
            EN    <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else if (KILL) begin
            state <= IDLE;
            CUR   <= '0;
            tgt   <= '0;
            cnt   <= '0;
            EN    <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (REQ) begin
                tgt <= lvl_clip;
            end
            case (state)
                IDLE: begin
                    if (REQ) begin
                        cnt <= '0;
                        if (lvl_clip > CUR) begin
                            state <= UP;
                            BUSY  <= 1'b1;
                        end else if (lvl_clip < CUR) begin
                            state <= DN;
                            BUSY  <= 1'b1;
                        end else begin
                            DONE <= 1'b1;
                        end
                    end
                end
                UP, DN: begin
                    // Dwell counter runs on across retargets so spacing
                    // between segment changes is never shortened.
                    if (stepping) begin
                        CUR <= cur_nxt;
                        EN  <= therm(cur_nxt);
                        cnt <= STEP;
                    end else begin
                        cnt <= cnt - STEP_W'(1);
                    end
                    if (cur_nxt == tgt_nxt) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else if (tgt_nxt > cur_nxt) begin
                        state <= UP;
                    end else begin
                        state <= DN;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buf_drive_sequencer.sv
// tb_buf_drive_sequencer: directed scoreboard bench for
// buf_drive_sequencer with NSEG=4, STEP_W=4.
module tb_buf_drive_sequencer;

    localparam int NSEG   = 4;
    localparam int STEP_W = 4;
    localparam int LW     = 3;

    logic              clk  = 1'b0;
    logic              rn   = 1'b0;
    logic              req  = 1'b0;
    logic              kill = 1'b0;
    logic [LW-1:0]     lvl  = '0;
    logic [STEP_W-1:0] step = '0;
    logic [NSEG-1:0]   en;
    logic [LW-1:0]     cur;
    logic              busy;
    logic              done;
    wire               vdd;
    wire               vss;

    assign vdd = 1'b1;
    assign vss = 1'b0;

    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    typedef struct packed {
        logic [NSEG-1:0] en;
        logic [LW-1:0]   cur;
        logic            busy;
        logic            done;
    } obs_t;

    obs_t sb[$];

    always #5 clk = ~clk;

    buf_drive_sequencer #(
        .NSEG  (NSEG),
        .STEP_W(STEP_W)
    ) dut (
        .CLK (clk),
        .RN  (rn),
        .VDD (vdd),
        .VSS (vss),
        .REQ (req),
        .LVL (lvl),
        .STEP(step),
        .KILL(kill),
        .EN  (en),
        .CUR (cur),
        .BUSY(busy),
        .DONE(done)
    );

    function automatic logic [NSEG-1:0] therm(input int c);
        logic [NSEG-1:0] t;
        t = '0;
        for (int i = 0; i < NSEG; i++) begin
            t[i] = (i < c);
        end
        return t;
    endfunction

    task automatic push(input int c, input logic b, input logic d);
        sb.push_back(obs_t'{en: therm(c), cur: LW'(c), busy: b, done: d});
    endtask

    task automatic check_one(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h",
                   phase, tag, obs, exp);
        end
    endtask

    task automatic compare();
        obs_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s/queue: observed empty expected entry", phase);
        end else begin
            e = sb.pop_front();
            check_one("en", 8'(en), 8'(e.en));
            check_one("cur", 8'(cur), 8'(e.cur));
            check_one("busy", 8'(busy), 8'(e.busy));
            check_one("done", 8'(done), 8'(e.done));
        end
    endtask

    // One clock: REQ/KILL are strobes, dropped right after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        req  = 1'b0;
        kill = 1'b0;
        compare();
    endtask

    task automatic expect_n(input int n, input int c, input logic b,
                            input logic d);
        repeat (n) begin
            push(c, b, d);
            tick();
        end
    endtask

    initial begin
        #2;
        push(0, 0, 0);
        compare();
        expect_n(2, 0, 0, 0);
        rn = 1'b1;
        expect_n(1, 0, 0, 0);

        phase = "t1_up_step2";
        step = 4'd2;
        lvl  = 3'd4;
        req  = 1'b1;
        expect_n(1, 0, 1, 0);
        expect_n(3, 1, 1, 0);
        expect_n(3, 2, 1, 0);
        expect_n(3, 3, 1, 0);
        expect_n(1, 4, 0, 1);
        expect_n(1, 4, 0, 0);

        phase = "t2_down_step0";
        step = 4'd0;
        lvl  = 3'd1;
        req  = 1'b1;
        expect_n(1, 4, 1, 0);
        expect_n(1, 3, 1, 0);
        expect_n(1, 2, 1, 0);
        expect_n(1, 1, 0, 1);
        expect_n(1, 1, 0, 0);

        phase = "t3_clip";
        lvl = 3'd7;
        req = 1'b1;
        expect_n(1, 1, 1, 0);
        expect_n(1, 2, 1, 0);
        expect_n(1, 3, 1, 0);
        expect_n(1, 4, 0, 1);
        expect_n(1, 4, 0, 0);

        phase = "t3_same_level";
        lvl = 3'd4;
        req = 1'b1;
        expect_n(1, 4, 0, 1);
        expect_n(2, 4, 0, 0);

        phase = "t4_to_zero";
        lvl = 3'd0;
        req = 1'b1;
        expect_n(1, 4, 1, 0);
        expect_n(1, 3, 1, 0);
        expect_n(1, 2, 1, 0);
        expect_n(1, 1, 1, 0);
        expect_n(1, 0, 0, 1);
        expect_n(1, 0, 0, 0);

        phase = "t4_retarget";
        step = 4'd3;
        lvl  = 3'd4;
        req  = 1'b1;
        expect_n(1, 0, 1, 0);
        expect_n(4, 1, 1, 0);
        expect_n(1, 2, 1, 0);
        lvl = 3'd0;
        req = 1'b1;
        expect_n(3, 2, 1, 0);
        expect_n(4, 1, 1, 0);
        expect_n(1, 0, 0, 1);
        expect_n(2, 0, 0, 0);

        phase = "t5_kill";
        step = 4'd0;
        lvl  = 3'd4;
        req  = 1'b1;
        expect_n(1, 0, 1, 0);
        expect_n(1, 1, 1, 0);
        expect_n(1, 2, 1, 0);
        expect_n(1, 3, 1, 0);
        kill = 1'b1;
        expect_n(2, 0, 0, 0);
        phase = "t5_kill_req";
        kill = 1'b1;
        req  = 1'b1;
        lvl  = 3'd3;
        expect_n(3, 0, 0, 0);

        phase = "t6_async_reset";
        step = 4'd1;
        lvl  = 3'd4;
        req  = 1'b1;
        expect_n(1, 0, 1, 0);
        expect_n(2, 1, 1, 0);
        expect_n(1, 2, 1, 0);
        #3;
        rn = 1'b0;
        #1;
        push(0, 0, 0);
        compare();
        expect_n(1, 0, 0, 0);
        #3;
        rn = 1'b1;

        phase = "t6_after_reset";
        step = 4'd0;
        lvl  = 3'd2;
        req  = 1'b1;
        expect_n(1, 0, 1, 0);
        expect_n(1, 1, 1, 0);
        expect_n(1, 2, 0, 1);
        expect_n(2, 2, 0, 0);

        phase = "end";
        check_one("sb_left", 8'(sb.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
